mlp_pio_ext: RTL and testbench

- Parametrised Avalon-MM slave parallel I/O port for the DE10-Lite MLP computer; replaces the fixed 10-bit output-only LED/switch PIOs.
- Per-bit direction and atomic bit set/clear writes.
- Inputs are synchronised and rising/falling/any-edge capture drives a maskable level interrupt to the CPU.

---
 rtl/mlp_pio_pkg.sv | 22 ++
 rtl/mlp_pio_sync.sv | 25 ++
 rtl/mlp_pio_ext.sv | 123 ++++++++++++
 tb/tb_mlp_pio_ext.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pio_pkg.sv
// Shared constants for the MLP parallel I/O port: register map, edge modes,
// and the read-data zero-extension helper.
package mlp_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Clears every bit at or above the port width.
  function automatic logic [31:0] zext_rd(input logic [31:0] val, input int width);
    if (width >= 32) return val;
    return val & ((32'h1 << width) - 32'h1);
  endfunction

endpackage

// File: rtl/mlp_pio_sync.sv
// Single-bit multi-flop synchroniser for an input asynchronous to clk.
module mlp_pio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain_q <= '0;
    else          chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/mlp_pio_ext.sv
// Avalon-MM parallel I/O port with per-bit direction, atomic set/clear,
// synchronised inputs and maskable edge-capture interrupt.
module mlp_pio_ext
  import mlp_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] in_prev_q, in_prev_d;
  logic [2:0]            settle_q, settle_d;
  logic                  irq_q, irq_d;

  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] w1c;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  wr_en;
  logic                  unused_wdata;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_sync
    mlp_pio_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port[i]),
      .q       (in_sync[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    w1c        = '0;
    in_prev_d  = in_sync;
    settle_d   = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 3'd1;

    case (EDGE_TYPE)
      EDGE_FALLING: edge_det = ~in_sync & in_prev_q;
      EDGE_ANY:     edge_det = in_sync ^ in_prev_q;
      default:      edge_det = in_sync & ~in_prev_q;
    endcase
    // Qualification uses the pre-write direction; nothing captures until settled.
    edge_det = edge_det & ~dir_q & {DATA_WIDTH{settle_q == SETTLE_MAX}};

    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_out_d = wdata;
        ADDR_DIR:      dir_d      = wdata;
        ADDR_IRQ_MASK: mask_d     = wdata;
        ADDR_EDGE_CAP: w1c        = wdata;
        ADDR_OUTSET:   data_out_d = data_out_q | wdata;
        ADDR_OUTCLEAR: data_out_d = data_out_q & ~wdata;
        default:       ;
      endcase
    end

    cap_d = (cap_q & ~w1c) | edge_det;
    irq_d = |(cap_d & mask_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= RESET_DIR;
      mask_q     <= '0;
      cap_q      <= '0;
      in_prev_q  <= '0;
      settle_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      in_prev_q  <= in_prev_d;
      settle_q   <= settle_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA:     rd_val = (dir_q & data_out_q) | (~dir_q & in_sync);
      ADDR_DIR:      rd_val = dir_q;
      ADDR_IRQ_MASK: rd_val = mask_q;
      ADDR_EDGE_CAP: rd_val = cap_q;
      default:       rd_val = '0;
    endcase
  end

  assign readdata = zext_rd(32'(rd_val), DATA_WIDTH);
  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mlp_pio_ext.sv
// Directed plus randomized bench for mlp_pio_ext against a sample-history reference model.
module tb_mlp_pio_ext;
  localparam int W    = 10;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata, readdata_b;
  logic [W-1:0]  in_port, out_port, oe, out_port_b, oe_b;
  logic          irq, irq_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mlp_pio_ext #(.DATA_WIDTH(W), .RESET_VALUE(10'h155), .RESET_DIR(10'h3FF),
                .SYNC_STAGES(SYNC), .EDGE_TYPE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  // Second port: all inputs, any-edge capture, never written; read fixed at EDGE_CAPTURE.
  mlp_pio_ext #(.DATA_WIDTH(W), .RESET_VALUE(10'h000), .RESET_DIR(10'h000),
                .SYNC_STAGES(SYNC), .EDGE_TYPE(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(3'd3), .chipselect(1'b0),
    .write_n(1'b1), .writedata(32'h0), .readdata(readdata_b),
    .in_port(in_port), .out_port(out_port_b), .oe(oe_b), .irq(irq_b)
  );

  // Reference model: registers plus the history of in_port sampled at each edge since reset.
  logic [W-1:0] m_dout, m_dir, m_mask, m_cap, m_cap_b;
  logic         m_irq;
  logic [W-1:0] samp[$];

  // Pin value seen by software after k edges: the sample taken SYNC-1 edges earlier.
  function automatic logic [W-1:0] sync_at(int k);
    if (k < SYNC) return '0;
    return samp[k-SYNC];
  endfunction

  task automatic model_reset();
    m_dout = 10'h155; m_dir = 10'h3FF; m_mask = '0; m_cap = '0; m_cap_b = '0;
    m_irq = 1'b0;
    samp.delete();
  endtask

  task automatic model_step();
    int k;
    logic [W-1:0] now_s, old_s, rise, fall, ev, ev_b, w1c;
    if (!reset_n) begin
      model_reset();
      return;
    end
    k = samp.size();
    now_s = sync_at(k);
    old_s = sync_at(k - 1);
    rise = now_s & ~old_s;
    fall = ~now_s & old_s;
    ev   = (k >= SYNC + 1) ? (rise & ~m_dir) : '0;
    ev_b = (k >= SYNC + 1) ? (rise | fall)   : '0;
    w1c  = '0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_dout = writedata[W-1:0];
        3'd1: m_dir  = writedata[W-1:0];
        3'd2: m_mask = writedata[W-1:0];
        3'd3: w1c    = writedata[W-1:0];
        3'd4: m_dout = m_dout | writedata[W-1:0];
        3'd5: m_dout = m_dout & ~writedata[W-1:0];
        default: ;
      endcase
    end
    m_cap   = (m_cap & ~w1c) | ev;
    m_cap_b = m_cap_b | ev_b;
    m_irq   = |(m_cap & m_mask);
    samp.push_back(in_port);
  endtask

  function automatic logic [31:0] exp_read(logic [2:0] a);
    case (a)
      3'd0: return 32'((m_dir & m_dout) | (~m_dir & sync_at(samp.size())));
      3'd1: return 32'(m_dir);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_cap);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out_port", 32'(out_port), 32'(m_dout));
    check("oe", 32'(oe), 32'(m_dir));
    check("irq", 32'(irq), 32'(m_irq));
    check("readdata", readdata, exp_read(address));
    check("cap_b", readdata_b, 32'(m_cap_b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    repeat (3) cyc();
    reset_n = 1'b1;
    #1;
    check("rst_out_port", 32'(out_port), 32'h155);
    check("rst_oe", 32'(oe), 32'h3FF);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rd_data", readdata, 32'h155);
    address = 3'd6; #1;
    check("rst_rd_rsvd", readdata, 32'h0);

    // Output data, set and clear
    bus_write(3'd0, 32'h0F0);
    check("wr_data", 32'(out_port), 32'h0F0);
    bus_write(3'd4, 32'h003);
    check("wr_outset", 32'(out_port), 32'h0F3);
    bus_write(3'd5, 32'h030);
    check("wr_outclr", 32'(out_port), 32'h0C3);
    address = 3'd4; #1; check("rd_outset", readdata, 32'h0);
    address = 3'd5; #1; check("rd_outclr", readdata, 32'h0);
    bus_write(3'd4, 32'hFFFF_FC00);
    check("upper_outset", 32'(out_port), 32'h0C3);
    bus_write(3'd0, 32'hFFFF_FC00 | 32'h0C3);
    check("upper_data", 32'(out_port), 32'h0C3);

    // Input path latency and mixed direction
    bus_write(3'd1, 32'h000);
    address = 3'd0; in_port = 10'h2AA;
    cyc(); check("in_lat_n", readdata, 32'h0);
    cyc(); check("in_lat_n1", readdata, 32'h2AA);
    bus_write(3'd1, 32'h00F);
    bus_write(3'd0, 32'h005);
    address = 3'd0; #1;
    check("mixed_read", readdata, 32'h2A5);

    // Rising edge capture and irq
    in_port = '0;
    repeat (4) cyc();
    bus_write(3'd3, 32'h3FF);
    bus_write(3'd2, 32'h001);
    bus_write(3'd1, 32'h000);
    address = 3'd3; in_port = 10'h001;
    cyc(); cyc();
    check("irq_early", 32'(irq), 32'h0);
    cyc();
    check("irq_rise", 32'(irq), 32'h1);
    check("cap_rise", readdata, 32'h001);
    in_port = '0;
    repeat (4) cyc();
    check("cap_fall_none", readdata, 32'h001);
    bus_write(3'd3, 32'h001);
    check("irq_w1c", 32'(irq), 32'h0);

    // Edge and W1C on the same bit in the same cycle
    in_port = 10'h001;
    cyc(); cyc();
    bus_write(3'd3, 32'h001);
    check("set_wins_cap", readdata, 32'h001);
    check("set_wins_irq", 32'(irq), 32'h1);
    bus_write(3'd2, 32'h000);
    check("mask_clr_irq", 32'(irq), 32'h0);
    address = 3'd3; #1;
    check("mask_clr_cap", readdata, 32'h001);
    bus_write(3'd2, 32'h001);
    check("mask_set_irq", 32'(irq), 32'h1);

    // Asynchronous reset while irq is high
    address = 3'd3;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_cap", readdata, 32'h0);
    check("async_out", 32'(out_port), 32'h155);

    // Inputs high through reset release must not capture
    in_port = 10'h3FF;
    repeat (3) cyc();
    reset_n = 1'b1;
    bus_write(3'd1, 32'h000);
    bus_write(3'd2, 32'h3FF);
    address = 3'd3;
    repeat (5) cyc();
    check("settle_cap", readdata, 32'h0);
    check("settle_irq", 32'(irq), 32'h0);
    check("settle_cap_b", readdata_b, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) in_port = W'($urandom);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 2) != 0);
      write_n    = ($urandom_range(0, 1) == 1);
      cyc();
    end
    chipselect = 1'b0; write_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
